// File: rtl/mult_share_arbiter.sv
//------------------------------------------------------------------------------
// mult_share_arbiter: round-robin sharing of one 8x8 unsigned multiplier.
// Optional macro MULT_ARB_FAST_EN removes the CALC stage (2-cycle op).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wallace_multiplier (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);
    logic [15:0] w_pp [8];
    logic [15:0] w_s  [9];
    logic [15:0] w_c  [9];

    assign w_s[0] = 16'd0;
    assign w_c[0] = 16'd0;

    // Each row folds one partial product into a carry-save pair; one final adder.
    for (genvar g = 0; g < 8; g++) begin : g_rows
        assign w_pp[g]  = b_i[g] ? ({8'd0, a_i} << g) : 16'd0;
        assign w_s[g+1] = w_s[g] ^ w_c[g] ^ w_pp[g];
        assign w_c[g+1] = ((w_s[g] & w_c[g]) | (w_s[g] & w_pp[g]) | (w_c[g] & w_pp[g])) << 1;
    end

    assign p_o = w_s[8] + w_c[8];
endmodule

module mult_share_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*8-1:0]       req_a_i,
    input  logic [NUM_REQ*8-1:0]       req_b_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
    output logic [15:0]                rsp_prod_o,
    output logic                       busy_o
);
    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [1:0] IDLE = 2'd0;
`ifndef MULT_ARB_FAST_EN
    localparam logic [1:0] CALC = 2'd1;
`endif
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [15:0]        rsp_prod_q;

    logic [NUM_REQ-1:0] w_rot;
    logic               w_found;
    logic [ID_W-1:0]    w_win;
    logic [ID_W:0]      w_sum;
    logic [ID_W-1:0]    w_rr_next;
    logic [7:0]         w_sel_a, w_sel_b;
    logic [7:0]         w_mul_a, w_mul_b;
    logic [15:0]        w_prod;
    logic               w_xfer;

    // Rotate so bit 0 is the requester at rr_ptr, then take the first set bit.
    always_comb begin
        w_rot   = NUM_REQ'({req_valid_i, req_valid_i} >> rr_ptr_q);
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
                if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
                    w_sum = w_sum - (ID_W+1)'(NUM_REQ);
                end
                w_win = w_sum[ID_W-1:0];
            end
        end
    end

    assign w_rr_next = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    assign w_sel_a   = req_a_i[{w_win, 3'b000} +: 8];
    assign w_sel_b   = req_b_i[{w_win, 3'b000} +: 8];
    assign w_xfer    = (state_q == IDLE) && w_found;

    // Ready is also masked by reset so nothing looks granted while rst_n is low.
    always_comb begin
        req_ready_o = '0;
        if (rst_n && w_xfer) begin
            req_ready_o[w_win] = 1'b1;
        end
    end

`ifdef MULT_ARB_FAST_EN
    assign w_mul_a = w_sel_a;
    assign w_mul_b = w_sel_b;
`else
    logic [7:0]      op_a_q, op_b_q;
    logic [ID_W-1:0] op_id_q;

    assign w_mul_a = op_a_q;
    assign w_mul_b = op_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q  <= 8'd0;
            op_b_q  <= 8'd0;
            op_id_q <= '0;
        end else if (w_xfer) begin
            op_a_q  <= w_sel_a;
            op_b_q  <= w_sel_b;
            op_id_q <= w_win;
        end
    end
`endif

    wallace_multiplier u_mult (
        .a_i (w_mul_a),
        .b_i (w_mul_b),
        .p_o (w_prod)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef MULT_ARB_FAST_EN
            IDLE:    if (w_found) state_d = RESP;
`else
            IDLE:    if (w_found) state_d = CALC;
            CALC:    state_d = RESP;
`endif
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            rsp_id_q   <= '0;
            rsp_prod_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (w_xfer) begin
                rr_ptr_q <= w_rr_next;
            end
`ifdef MULT_ARB_FAST_EN
            if (w_xfer) begin
                rsp_prod_q <= w_prod;
                rsp_id_q   <= w_win;
            end
`else
            if (state_q == CALC) begin
                rsp_prod_q <= w_prod;
                rsp_id_q   <= op_id_q;
            end
`endif
        end
    end

    assign rsp_valid_o = (state_q == RESP);
    assign rsp_id_o    = rsp_id_q;
    assign rsp_prod_o  = rsp_prod_q;
    assign busy_o      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
//------------------------------------------------------------------------------
// tb_mult_share_arbiter: directed and random checks of mult_share_arbiter.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mult_share_arbiter;
    localparam int N = 4;
`ifdef MULT_ARB_FAST_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*8-1:0]   req_a = '0;
    logic [N*8-1:0]   req_b = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [1:0]       rsp_id;
    logic [15:0]      rsp_prod;
    logic             busy;

    mult_share_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_prod_o  (rsp_prod),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct { int id; int prod; } op_t;

    int   tests = 0;
    int   fails = 0;
    // Reference: phase 0 = free, 1 = computing, 2 = holding a result
    int   m_phase = 0;
    int   m_rr = 0;
    op_t  sb[$];
    int   grant_log[$];
    int   grant_cyc[$];
    int   cyc = 0;
    int   n_acc = 0;
    int   n_done = 0;
    int   hs_id, hs_prod, hs_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; checks mid-cycle, then advances the model over the edge.
    task automatic step(output int granted);
        int win;
        int exp_rdy;
        bit hs;
        #4;
        win = -1;
        if (m_phase == 0 && rst_n) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && req_valid[(m_rr + k) % N]) win = (m_rr + k) % N;
            end
        end
        exp_rdy = (win >= 0) ? (1 << win) : 0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        if (m_phase == 2) begin
            chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
            chk("rsp_prod", 32'(rsp_prod), 32'(sb[0].prod));
        end
        hs = (m_phase == 2) && rsp_ready;
        if (hs) begin
            hs_id = int'(rsp_id); hs_prod = int'(rsp_prod); hs_cyc = cyc; n_done++;
        end
        if (win >= 0) begin
            grant_log.push_back(win);
            grant_cyc.push_back(cyc);
        end
        granted = win;
        @(posedge clk);
        cyc++;
        case (m_phase)
            0: if (win >= 0) begin
                sb.push_back('{win, int'(req_a[win*8 +: 8]) * int'(req_b[win*8 +: 8])});
                m_rr = (win + 1) % N;
                m_phase = (LAT == 1) ? 2 : 1;
                n_acc++;
            end
            1: m_phase = 2;
            default: if (hs) begin
                void'(sb.pop_front());
                m_phase = 0;
            end
        endcase
        #1;
    endtask

    // One operation from requester i with rsp_ready held high; returns grant cycle.
    task automatic run_one(input int i, input logic [7:0] a, input logic [7:0] b, output int gcyc);
        int g;
        int done0;
        int n;
        rsp_ready = 1'b1;
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_valid = N'(1 << i);
        g = -1; n = 0; gcyc = -1;
        while (g < 0 && n < 10) begin
            step(g);
            n++;
        end
        gcyc = cyc - 1;
        chk("grant_timeout", 32'(g), 32'(i));
        req_valid = '0;
        done0 = n_done; n = 0;
        while (n_done == done0 && n < 10) begin
            step(g);
            n++;
        end
        chk("resp_timeout", 32'(n_done - done0), 32'd1);
    endtask

    initial begin
        int g, gc, n, p0, id0;
        int exp_order[6];
        int acc0, done0;
        exp_order = '{0, 1, 2, 3, 0, 1};

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_prod", 32'(rsp_prod), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Single request 13*11
        run_one(0, 8'd13, 8'd11, gc);
        chk("single_prod", 32'(hs_prod), 32'd143);
        chk("single_id", 32'(hs_id), 32'd0);
        chk("single_lat", 32'(hs_cyc - gc), 32'(LAT));

        // Max and zero operands
        run_one(3, 8'hFF, 8'hFF, gc);
        chk("max_prod", 32'(hs_prod), 32'hFE01);
        chk("max_id", 32'(hs_id), 32'd3);
        run_one(3, 8'h00, 8'hA5, gc);
        chk("zero_prod", 32'(hs_prod), 32'd0);

        // All requesters valid: strict rotation from 0
        for (int i = 0; i < N; i++) begin
            req_a[i*8 +: 8] = 8'($urandom);
            req_b[i*8 +: 8] = 8'($urandom);
        end
        grant_log.delete(); grant_cyc.delete();
        req_valid = '1; rsp_ready = 1'b1; n = 0;
        while (grant_log.size() < 6 && n < 40) begin
            step(g);
            n++;
        end
        req_valid = '0;
        chk("rot_count", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk($sformatf("rot_order%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));
        for (int i = 0; i + 1 < grant_cyc.size(); i++)
            chk($sformatf("rot_gap%0d", i), 32'(grant_cyc[i+1] - grant_cyc[i]), 32'(LAT + 1));
        for (int i = 0; i < 4; i++) step(g);

        // Backpressure with req1 waiting
        rsp_ready = 1'b0;
        req_a[7:0] = 8'd200; req_b[7:0] = 8'd77;
        req_valid = 4'b0001; g = -1; n = 0;
        while (g < 0 && n < 10) begin step(g); n++; end
        req_valid = '0; n = 0;
        while (!rsp_valid && n < 10) begin step(g); n++; end
        p0 = int'(rsp_prod); id0 = int'(rsp_id);
        chk("bp_prod0", 32'(p0), 32'd15400);
        req_a[15:8] = 8'd9; req_b[15:8] = 8'd7;
        req_valid = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            step(g);
            chk("bp_prod_hold", 32'(rsp_prod), 32'(p0));
            chk("bp_id_hold", 32'(rsp_id), 32'(id0));
        end
        rsp_ready = 1'b1;
        step(g);
        step(g);
        chk("bp_grant1", 32'(g), 32'd1);
        req_valid = '0;
        for (int i = 0; i < 4; i++) step(g);

        // Reset while an operation is in flight
        req_valid = 4'b0001; g = -1; n = 0;
        while (g < 0 && n < 10) begin step(g); n++; end
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_id", 32'(rsp_id), 32'd0);
        chk("mid_rst_prod", 32'(rsp_prod), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        sb.delete(); m_phase = 0; m_rr = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 4'b1010;
        step(g);
        chk("post_rst_grant", 32'(g), 32'd1);
        req_valid = '0;
        for (int i = 0; i < 4; i++) step(g);

        // Random traffic
        acc0 = n_acc; done0 = n_done; n = 0;
        for (int i = 0; i < N; i++) begin
            req_a[i*8 +: 8] = 8'($urandom);
            req_b[i*8 +: 8] = 8'($urandom);
        end
        while ((n_acc - acc0) < 4000 && n < 60000) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            step(g);
            n++;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && i != g) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    req_a[i*8 +: 8] = 8'($urandom);
                    req_b[i*8 +: 8] = 8'($urandom);
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        chk("rand_budget", 32'(n_acc - acc0 >= 4000), 32'd1);
        req_valid = '0; rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) step(g);
        chk("rand_sb_empty", 32'(sb.size()), 32'd0);
        chk("rand_all_returned", 32'(n_done - done0), 32'(n_acc - acc0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
